// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM receiver: frame-sync alignment, slot counter, registered frame output
// Slots 0..2 are buffered in shadow; slot 3 goes straight from sin into d when the frame completes.
module tdm_demux4 #(
   parameter int FCW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           sin,
   input  logic           sync,
   output logic           a,
   output logic           b,
   output logic           c,
   output logic           d,
   output logic           frame_valid,
   output logic [1:0]     sel,
   output logic           locked,
   output logic           sync_err,
   output logic [FCW-1:0] frame_cnt
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t         state, state_nxt;
   logic [1:0]     sel_nxt;
   logic [2:0]     shadow, shadow_nxt;
   logic [3:0]     frame, frame_nxt;
   logic           frame_valid_nxt;
   logic           sync_err_nxt;
   logic [FCW-1:0] frame_cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         sel         <= 2'd0;
         shadow      <= 3'b000;
         frame       <= 4'b0000;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         state       <= state_nxt;
         sel         <= sel_nxt;
         shadow      <= shadow_nxt;
         frame       <= frame_nxt;
         frame_valid <= frame_valid_nxt;
         sync_err    <= sync_err_nxt;
         frame_cnt   <= frame_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      sel_nxt         = sel;
      shadow_nxt      = shadow;
      frame_nxt       = frame;
      frame_valid_nxt = 1'b0;
      sync_err_nxt    = 1'b0;
      frame_cnt_nxt   = frame_cnt;

      if (en) begin
         case (state)
            HUNT: begin
               if (sync) begin
                  shadow_nxt[0] = sin;
                  sel_nxt       = 2'd1;
                  state_nxt     = LOCKED;
               end
            end
            LOCKED: begin
               if (sync && (sel != 2'd0)) begin
                  // Realign: the partial frame is dropped and this bit restarts at slot 0.
                  sync_err_nxt  = 1'b1;
                  shadow_nxt[0] = sin;
                  sel_nxt       = 2'd1;
               end else begin
                  case (sel)
                     2'd0: shadow_nxt[0] = sin;
                     2'd1: shadow_nxt[1] = sin;
                     2'd2: shadow_nxt[2] = sin;
                     default: begin
                        frame_nxt       = {shadow[0], shadow[1], shadow[2], sin};
                        frame_valid_nxt = 1'b1;
                        frame_cnt_nxt   = frame_cnt + FCW'(1);
                     end
                  endcase
                  sel_nxt = sel + 2'd1;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   assign {a, b, c, d} = frame;
   assign locked       = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed self-checking bench for tdm_demux4
// A second instance with FCW=2 shares all inputs and is used for the counter-wrap check.
module tb_tdm_demux4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       sin = 1'b0;
   logic       sync = 1'b0;
   logic       a, b, c, d, frame_valid, locked, sync_err;
   logic [1:0] sel;
   logic [3:0] frame_cnt;
   logic       a2, b2, c2, d2, frame_valid2, locked2, sync_err2;
   logic [1:0] sel2;
   logic [1:0] frame_cnt2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   tdm_demux4 #(.FCW(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sin(sin), .sync(sync),
      .a(a), .b(b), .c(c), .d(d), .frame_valid(frame_valid), .sel(sel),
      .locked(locked), .sync_err(sync_err), .frame_cnt(frame_cnt)
   );

   tdm_demux4 #(.FCW(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .sin(sin), .sync(sync),
      .a(a2), .b(b2), .c(c2), .d(d2), .frame_valid(frame_valid2), .sel(sel2),
      .locked(locked2), .sync_err(sync_err2), .frame_cnt(frame_cnt2)
   );

   task automatic step(input logic e, input logic s, input logic y);
      en = e; sin = s; sync = y;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
         tests++;
         if ({a, b, c, d, frame_valid, sync_err, locked, sel, frame_cnt} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {a, b, c, d, frame_valid, sync_err, locked, sel, frame_cnt});
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_hunt_two_frames();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      tests++;
      if ({locked, sel, frame_valid} !== 4'b0000) begin
         fails++;
         $display("FAIL hunt_ignore: locked/sel/fv=%b required 0000", {locked, sel, frame_valid});
      end
      step(1'b1, 1'b1, 1'b1);
      tests++;
      if ({locked, sel} !== 3'b101) begin
         fails++;
         $display("FAIL hunt_lock: locked/sel=%b required 101", {locked, sel});
      end
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      tests++;
      if ({sel, frame_valid} !== 3'b110) begin
         fails++;
         $display("FAIL frame1_pre: sel/fv=%b required 110", {sel, frame_valid});
      end
      step(1'b1, 1'b1, 1'b0);
      tests++;
      if ({a, b, c, d, frame_valid, frame_cnt, sel} !== {4'b1001, 1'b1, 4'd1, 2'd0}) begin
         fails++;
         $display("FAIL frame1: abcd=%b fv=%b cnt=%0d sel=%0d required 1001 1 1 0",
                  {a, b, c, d}, frame_valid, frame_cnt, sel);
      end
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      tests++;
      if ({a, b, c, d, frame_valid} !== 5'b10010) begin
         fails++;
         $display("FAIL frame2_hold: abcd/fv=%b required 10010", {a, b, c, d, frame_valid});
      end
      step(1'b1, 1'b1, 1'b0);
      tests++;
      if ({a, b, c, d, frame_valid, frame_cnt} !== {4'b0101, 1'b1, 4'd2}) begin
         fails++;
         $display("FAIL frame2: abcd=%b fv=%b cnt=%0d required 0101 1 2",
                  {a, b, c, d}, frame_valid, frame_cnt);
      end
   endtask

   task automatic test_enable_gaps();
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
         tests++;
         if ({sel, frame_valid, sync_err} !== 4'b1000) begin
            fails++;
            $display("FAIL gap_hold: sel/fv/se=%b required 1000", {sel, frame_valid, sync_err});
         end
      end
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      tests++;
      if ({a, b, c, d, frame_valid, frame_cnt} !== {4'b1001, 1'b1, 4'd3}) begin
         fails++;
         $display("FAIL gap_frame: abcd=%b fv=%b cnt=%0d required 1001 1 3",
                  {a, b, c, d}, frame_valid, frame_cnt);
      end
   endtask

   task automatic test_misaligned_sync();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      tests++;
      if ({sync_err, sel, locked, a, b, c, d, frame_valid, frame_cnt} !==
          {1'b1, 2'd1, 1'b1, 4'b1001, 1'b0, 4'd3}) begin
         fails++;
         $display("FAIL misalign_err: se=%b sel=%0d locked=%b abcd=%b fv=%b cnt=%0d required 1 1 1 1001 0 3",
                  sync_err, sel, locked, {a, b, c, d}, frame_valid, frame_cnt);
      end
      step(1'b1, 1'b1, 1'b0);
      tests++;
      if ({sync_err, sel} !== 3'b010) begin
         fails++;
         $display("FAIL misalign_pulse: se/sel=%b required 010", {sync_err, sel});
      end
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      tests++;
      if ({a, b, c, d, frame_valid, frame_cnt} !== {4'b0110, 1'b1, 4'd4}) begin
         fails++;
         $display("FAIL misalign_frame: abcd=%b fv=%b cnt=%0d required 0110 1 4",
                  {a, b, c, d}, frame_valid, frame_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({a, b, c, d, frame_valid, sync_err, locked, sel, frame_cnt} !== 13'd0) begin
         fails++;
         $display("FAIL reset_async: got %b required all zero",
                  {a, b, c, d, frame_valid, sync_err, locked, sel, frame_cnt});
      end
      step(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'(i[0]), 1'b0);
         tests++;
         if ({locked, sel, frame_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_hunt: locked/sel/fv=%b required 0000", {locked, sel, frame_valid});
         end
      end
      step(1'b1, 1'b1, 1'b1);
      tests++;
      if ({locked, sel} !== 3'b101) begin
         fails++;
         $display("FAIL reset_relock: locked/sel=%b required 101", {locked, sel});
      end
   endtask

   task automatic test_counter_wrap();
      logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      logic [3:0] pat  [5] = '{4'b1100, 4'b0011, 4'b1010, 4'b0101, 4'b1111};
      logic [3:0] p;
      do_reset();
      for (int f = 0; f < 5; f++) begin
         p = pat[f];
         step(1'b1, p[3], 1'b1);
         step(1'b1, p[2], 1'b0);
         step(1'b1, p[1], 1'b0);
         step(1'b1, p[0], 1'b0);
         tests++;
         if ({frame_cnt2, frame_valid2, a2, b2, c2, d2} !== {exp2[f], 1'b1, p}) begin
            fails++;
            $display("FAIL wrap_fcw2: frame %0d cnt=%0d fv=%b abcd=%b required %0d 1 %b",
                     f, frame_cnt2, frame_valid2, {a2, b2, c2, d2}, exp2[f], p);
         end
         tests++;
         if (frame_cnt !== 4'(f + 1)) begin
            fails++;
            $display("FAIL wrap_fcw4: frame %0d cnt=%0d required %0d", f, frame_cnt, f + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_hunt_two_frames();
      test_enable_gaps();
      test_misaligned_sync();
      test_reset_mid_frame();
      test_counter_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Receive-side counterpart of the 4:1 select-driven multiplexer. The transmitter serializes four single-bit channels (a, b, c, d) onto one line by stepping a 2-bit select {s1,s0} through 0..3. This block recovers the four channels from that line. It tracks the slot with its own 2-bit counter, aligns to a frame-sync marker, and presents each completed frame as four registered outputs with a one-cycle valid strobe.

## Interface
- FCW, default 4: width of the completed-frame counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  slot-advance enable; one serial bit is consumed per clk edge with en=1.
- sin  in  1  serial data bit for the current slot.
- sync  in  1  marks the current bit as slot 0 (channel a); sampled only when en=1.
- a, b, c, d  out  1 each  last completed frame, registered (slot 0..3 respectively).
- frame_valid  out  1  one-cycle pulse: a..d just updated.
- sel  out  2  slot index the next enabled bit will occupy ({s1,s0}).
- locked  out  1  high while in LOCKED state.
- sync_err  out  1  one-cycle pulse: sync seen at a slot other than 0 while LOCKED.
- frame_cnt  out  FCW  number of completed frames, modulo 2^FCW.

## Operation
- The state machine has two states: HUNT and LOCKED. Reset enters HUNT.
- HUNT:
  - sin is ignored until an enabled bit arrives with sync=1.
  - That bit is stored as slot 0, sel becomes 1 and the state goes to LOCKED.
  - Enabled bits with sync=0 leave sel at 0 and are discarded.
- LOCKED, for each enabled bit:
  - The bit is written to shadow[sel], then sel increments modulo 4.
  - At sel=3 the edge loads {a,b,c,d} from {shadow[0], shadow[1], shadow[2], sin}.
  - The same edge pulses frame_valid and increments frame_cnt, which wraps from 2^FCW-1 to 0.
- sync=1 at sel=0 while LOCKED is a normal aligned marker and has no side effect.
- sync=1 at sel≠0 while LOCKED:
  - sync_err pulses and the partial frame is discarded.
  - The bit is stored as slot 0 and sel becomes 1.
  - a..d, frame_cnt and the state are unchanged, and no frame_valid is generated.
- sync is not required on every frame. Missing markers never cause loss of lock.
- en=0 freezes the state, sel, shadow, a..d and frame_cnt. frame_valid and sync_err are 0 in any cycle following an edge with en=0.
- The shadow register holds only slots 0..2. Slot 3 goes directly from sin into d.

## Timing
- Reset values (asynchronous, immediate on rst_n=0): state=HUNT, sel=0, shadow=0, a=b=c=d=0, frame_valid=0, sync_err=0, locked=0, frame_cnt=0.
- rst_n deasserts synchronously to clk. The first edge with rst_n=1 is an ordinary edge.
- All outputs are registered; no combinational path runs from an input to an output.
- Latency: if slot 0 is sampled at edge k, then a..d, frame_valid and frame_cnt update at edge k+3 (counting enabled edges only). They are visible during the cycle after that edge.
- frame_valid is high for exactly one cycle per completed frame. Back-to-back frames give a pulse every 4th enabled edge.
- locked rises on the edge that samples the first sync bit.
- sync_err rises on the edge that samples the misaligned sync.
- Reset mid-frame discards shadow and returns to HUNT. The next frame requires a new sync.

## Test plan
- **Reset:** hold rst_n=0 with clk running and random sin/sync → all outputs 0, locked=0, sel=0.
- **Hunt then two frames:**
  - Stimulus: en=1; bits 1,1 with sync=0, then frame 1,0,0,1 with sync on the first bit, then frame 0,1,0,1 with no sync.
  - Required: the two leading bits are ignored. After the 4th frame bit, a=1,b=0,c=0,d=1 with frame_valid=1 and frame_cnt=1. Four edges later, a=0,b=1,c=0,d=1 with frame_cnt=2.
- **Enable gaps:** same frame 1,0,0,1 with en=0 for 3 cycles between slots 1 and 2 → sel holds at 2, no frame_valid during the gap. Result a=1,b=0,c=0,d=1 on the 4th enabled edge.
- **Misaligned sync:**
  - Stimulus: while LOCKED, send 1,1 then sync with bit 0, followed by 1,1,0.
  - Required: sync_err pulses once and the previous a..d hold. The next frame_valid shows a=0,b=1,c=1,d=0.
- **Reset mid-frame:** pulse rst_n low after slot 1 → outputs 0 immediately, HUNT. Data without sync is ignored until the next sync.
- **Counter wrap:** FCW=2, send 5 complete frames → frame_cnt sequence 1,2,3,0,1.
